param_fifo_queue: RTL and testbench

Parametrised successor to the team's single-mode FIFO queue. It is a first-word-fall-through queue with generic depth and width, live occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and a selectable overflow mode (STALL or DROP_OLDEST). It sits between request producers and consumers in the memory and issue paths, where back-pressure or lossy buffering is chosen per instance.

---
 rtl/param_fifo_queue.sv | 126 ++++++++++++
 tb/tb_param_fifo_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo_queue.sv
// First-word-fall-through queue with live occupancy, programmable almost-full/empty
// thresholds, synchronous flush and a per-instance overflow mode (STALL or DROP_OLDEST).
module param_fifo_queue #(
    parameter int    QUEUE_SIZE                 = 16,
    parameter int    QUEUE_PTR_WIDTH_IN_BITS    = 4,
    parameter int    SINGLE_ENTRY_WIDTH_IN_BITS = 32,
    parameter string STORAGE_TYPE               = "LUTRAM",
    parameter string OVERFLOW_MODE              = "STALL"
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    input  logic                                 flush_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
    input  logic                                 request_valid_in,
    output logic                                 issue_ack_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out,
    output logic                                 request_valid_out,
    input  logic                                 issue_ack_in,
    input  logic [QUEUE_PTR_WIDTH_IN_BITS:0]     almost_full_threshold_in,
    input  logic [QUEUE_PTR_WIDTH_IN_BITS:0]     almost_empty_threshold_in,
    output logic [QUEUE_PTR_WIDTH_IN_BITS:0]     count_out,
    output logic                                 is_empty_out,
    output logic                                 is_full_out,
    output logic                                 almost_full_out,
    output logic                                 almost_empty_out,
    output logic [31:0]                          drop_ctr_out,
    output logic                                 underflow_error_out
);

    localparam int PW = QUEUE_PTR_WIDTH_IN_BITS;
    localparam int CW = QUEUE_PTR_WIDTH_IN_BITS + 1;
    localparam int W  = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_SIZE);
    localparam bit DROP_MODE = (OVERFLOW_MODE == "DROP_OLDEST");

    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [CW-1:0] count_q;
    logic [31:0]   drop_ctr_q;
    logic          underflow_q;
    logic [W-1:0]  head_data;

    logic push;
    logic pop;
    logic drop;
    logic head_advance;
    logic underflow_set;

    // Handshake: a write transfers on an edge where request_valid_in and issue_ack_out are
    // both high; a read transfers where request_valid_out and issue_ack_in are both high.
    // A producer may hold valid with ack low indefinitely; flush blocks both directions.
    always_comb begin
        is_empty_out      = (count_q == '0);
        is_full_out       = (count_q == FULL_COUNT);
        request_valid_out = ~is_empty_out;
        if (DROP_MODE) begin
            issue_ack_out = request_valid_in & ~flush_in;
        end else begin
            issue_ack_out = request_valid_in & ~is_full_out & ~flush_in;
        end
        push          = issue_ack_out;
        pop           = issue_ack_in & request_valid_out & ~flush_in;
        // Only a write into a full queue with no consumer pop evicts the oldest entry.
        drop          = DROP_MODE & push & is_full_out & ~pop;
        head_advance  = pop | drop;
        underflow_set = issue_ack_in & ~request_valid_out & ~flush_in;
    end

    if (STORAGE_TYPE == "FLOP") begin : g_flop_store
        (* ram_style = "registers" *) logic [W-1:0] mem [QUEUE_SIZE];
        always_ff @(posedge clk_in) begin
            if (push) begin
                mem[tail_ptr] <= request_in;
            end
        end
        assign head_data = mem[head_ptr];
    end else begin : g_lutram_store
        (* ram_style = "distributed" *) logic [W-1:0] mem [QUEUE_SIZE];
        always_ff @(posedge clk_in) begin
            if (push) begin
                mem[tail_ptr] <= request_in;
            end
        end
        assign head_data = mem[head_ptr];
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            head_ptr    <= '0;
            tail_ptr    <= '0;
            count_q     <= '0;
            drop_ctr_q  <= '0;
            underflow_q <= 1'b0;
        end else if (flush_in) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + PW'(1);
            end
            if (head_advance) begin
                head_ptr <= head_ptr + PW'(1);
            end
            if (push && !head_advance) begin
                count_q <= count_q + CW'(1);
            end else if (!push && head_advance) begin
                count_q <= count_q - CW'(1);
            end
            if (drop && (drop_ctr_q != '1)) begin
                drop_ctr_q <= drop_ctr_q + 32'd1;
            end
            if (underflow_set) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign request_out         = request_valid_out ? head_data : '0;
    assign count_out           = count_q;
    assign almost_full_out     = (count_q >= almost_full_threshold_in);
    assign almost_empty_out    = (count_q <= almost_empty_threshold_in);
    assign drop_ctr_out        = drop_ctr_q;
    assign underflow_error_out = underflow_q;

endmodule

// File: tb/tb_param_fifo_queue.sv
// Bench for param_fifo_queue: a STALL and a DROP_OLDEST instance share one stimulus stream,
// each with its own scoreboard queue and expected status.
module tb_param_fifo_queue;

    localparam int DEPTH = 16;
    localparam int PW    = 4;
    localparam int CW    = PW + 1;
    localparam int W     = 32;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          flush;
    logic          req_valid;
    logic          pop;
    logic [W-1:0]  req_data;
    logic [CW-1:0] af_th;
    logic [CW-1:0] ae_th;

    logic ack_s, vld_s, emp_s, ful_s, af_s, ae_s, uf_s;
    logic ack_d, vld_d, emp_d, ful_d, af_d, ae_d, uf_d;
    logic [W-1:0]  rd_s, rd_d;
    logic [CW-1:0] cnt_s, cnt_d;
    logic [31:0]   dc_s, dc_d;

    param_fifo_queue #(
        .QUEUE_SIZE(DEPTH), .QUEUE_PTR_WIDTH_IN_BITS(PW), .SINGLE_ENTRY_WIDTH_IN_BITS(W),
        .STORAGE_TYPE("LUTRAM"), .OVERFLOW_MODE("STALL")
    ) dut_stall (
        .clk_in(clk), .reset_in(rst_n), .flush_in(flush),
        .request_in(req_data), .request_valid_in(req_valid), .issue_ack_out(ack_s),
        .request_out(rd_s), .request_valid_out(vld_s), .issue_ack_in(pop),
        .almost_full_threshold_in(af_th), .almost_empty_threshold_in(ae_th),
        .count_out(cnt_s), .is_empty_out(emp_s), .is_full_out(ful_s),
        .almost_full_out(af_s), .almost_empty_out(ae_s),
        .drop_ctr_out(dc_s), .underflow_error_out(uf_s)
    );

    param_fifo_queue #(
        .QUEUE_SIZE(DEPTH), .QUEUE_PTR_WIDTH_IN_BITS(PW), .SINGLE_ENTRY_WIDTH_IN_BITS(W),
        .STORAGE_TYPE("FLOP"), .OVERFLOW_MODE("DROP_OLDEST")
    ) dut_drop (
        .clk_in(clk), .reset_in(rst_n), .flush_in(flush),
        .request_in(req_data), .request_valid_in(req_valid), .issue_ack_out(ack_d),
        .request_out(rd_d), .request_valid_out(vld_d), .issue_ack_in(pop),
        .almost_full_threshold_in(af_th), .almost_empty_threshold_in(ae_th),
        .count_out(cnt_d), .is_empty_out(emp_d), .is_full_out(ful_d),
        .almost_full_out(af_d), .almost_empty_out(ae_d),
        .drop_ctr_out(dc_d), .underflow_error_out(uf_d)
    );

    // scoreboard state
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int unsigned  drop_exp1;
    bit           uf_exp0;
    bit           uf_exp1;
    bit           last_ack_s;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_inst(input string p, input int sz, input logic [W-1:0] head,
                              input int unsigned dexp, input bit ufe,
                              input logic [CW-1:0] cnt, input logic emp, input logic ful,
                              input logic vld, input logic [W-1:0] rd, input logic afo,
                              input logic aeo, input logic [31:0] dc, input logic ufo);
        check({"count_", p},     32'(cnt), 32'(sz));
        check({"empty_", p},     32'(emp), 32'(sz == 0));
        check({"full_", p},      32'(ful), 32'(sz == DEPTH));
        check({"valid_", p},     32'(vld), 32'(sz != 0));
        check({"head_", p},      rd,       (sz != 0) ? head : '0);
        check({"afull_", p},     32'(afo), 32'(sz >= int'(af_th)));
        check({"aempty_", p},    32'(aeo), 32'(sz <= int'(ae_th)));
        check({"drop_ctr_", p},  dc,       dexp);
        check({"underflow_", p}, 32'(ufo), 32'(ufe));
    endtask

    task automatic check_state();
        check_inst("s", exp_q0.size(), (exp_q0.size() != 0) ? exp_q0[0] : '0, 0, uf_exp0,
                   cnt_s, emp_s, ful_s, vld_s, rd_s, af_s, ae_s, dc_s, uf_s);
        check_inst("d", exp_q1.size(), (exp_q1.size() != 0) ? exp_q1[0] : '0, drop_exp1, uf_exp1,
                   cnt_d, emp_d, ful_d, vld_d, rd_d, af_d, ae_d, dc_d, uf_d);
    endtask

    // driver: one cycle of traffic, called on the falling edge
    task automatic drive(input bit v, input logic [W-1:0] d, input bit p, input bit fl);
        bit exp_ack0, exp_ack1, do_pop0, do_pop1;
        req_valid = v;
        req_data  = d;
        pop       = p;
        flush     = fl;
        #1;
        exp_ack0 = v && !fl && (exp_q0.size() != DEPTH);
        exp_ack1 = v && !fl;
        do_pop0  = p && !fl && (exp_q0.size() != 0);
        do_pop1  = p && !fl && (exp_q1.size() != 0);
        check("ack_s", 32'(ack_s), 32'(exp_ack0));
        check("ack_d", 32'(ack_d), 32'(exp_ack1));
        last_ack_s = ack_s;
        if (do_pop0) check("pop_s", rd_s, exp_q0.pop_front());
        if (do_pop1) check("pop_d", rd_d, exp_q1.pop_front());
        if (p && !fl && !do_pop0) uf_exp0 = 1'b1;
        if (p && !fl && !do_pop1) uf_exp1 = 1'b1;
        if (exp_ack0) exp_q0.push_back(d);
        if (exp_ack1) begin
            if (exp_q1.size() == DEPTH) begin
                void'(exp_q1.pop_front());
                drop_exp1++;
            end
            exp_q1.push_back(d);
        end
        if (fl) begin
            exp_q0.delete();
            exp_q1.delete();
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        check_state();
    endtask

    task automatic apply_reset(input bit v, input logic [W-1:0] d);
        rst_n     = 1'b0;
        req_valid = v;
        req_data  = d;
        pop       = 1'b0;
        flush     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        drop_exp1 = 0;
        uf_exp0   = 1'b0;
        uf_exp1   = 1'b0;
        check_state();
    endtask

    initial begin
        int idx;
        int acks;
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; pop = 1'b0; req_data = '0;
        af_th = CW'(12); ae_th = CW'(3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        apply_reset(1'b0, '0);

        // ordered return with gaps between pops
        for (int i = 0; i < 8; i++) drive(1'b1, 32'hFFFF_FFFF - 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
        end
        check("t1_empty", 32'(emp_s), 32'd1);

        // STALL back-pressure with valid held; producer advances only on ack
        apply_reset(1'b0, '0);
        idx = 0;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h1000 + 32'(idx), 1'b0, 1'b0);
            if (last_ack_s) begin
                idx++;
                acks++;
            end
        end
        check("t2_acks", 32'(acks), 32'd16);
        check("t2_full", 32'(ful_s), 32'd1);
        drive(1'b1, 32'h1000 + 32'(idx), 1'b1, 1'b0);
        check("t2_no_ack_on_pop", 32'(last_ack_s), 32'd0);
        drive(1'b1, 32'h1000 + 32'(idx), 1'b0, 1'b0);
        check("t2_late_ack", 32'(last_ack_s), 32'd1);
        check("t2_head", rd_s, 32'h1001);
        repeat (16) drive(1'b0, '0, 1'b1, 1'b0);

        // DROP_OLDEST overflow
        apply_reset(1'b0, '0);
        for (int i = 0; i < 20; i++) drive(1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0);
        check("t3_drop_ctr", dc_d, 32'd4);
        check("t3_count", 32'(cnt_d), 32'd16);
        check("t3_head", rd_d, 32'h2004);
        repeat (16) drive(1'b0, '0, 1'b1, 1'b0);

        // thresholds
        apply_reset(1'b0, '0);
        for (int i = 0; i < 11; i++) drive(1'b1, $urandom_range(0, 32'hFFFF), 1'b0, 1'b0);
        check("t4_af_at11", 32'(af_s), 32'd0);
        drive(1'b1, $urandom_range(0, 32'hFFFF), 1'b0, 1'b0);
        check("t4_af_at12", 32'(af_s), 32'd1);
        drive(1'b1, 32'h4444, 1'b1, 1'b0);
        check("t4_af_pushpop", 32'(af_s), 32'd1);
        repeat (9) drive(1'b0, '0, 1'b1, 1'b0);
        check("t4_ae_at3", 32'(ae_s), 32'd1);
        af_th = '0;
        ae_th = CW'(16);
        drive(1'b0, '0, 1'b0, 1'b0);
        af_th = CW'(12);
        ae_th = CW'(3);
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

        // flush with concurrent traffic, then underflow
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h5000 + 32'(i), 1'b0, 1'b0);
        drive(1'b1, 32'h5555, 1'b1, 1'b1);
        check("t5_count", 32'(cnt_s), 32'd0);
        check("t5_rdata", rd_s, 32'd0);
        check("t5_uf_clear", 32'(uf_s), 32'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("t5_uf_set", 32'(uf_s), 32'd1);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h5100 + 32'(i), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1);
        check("t5_uf_sticky", 32'(uf_s), 32'd1);

        // reset mid-stream with a same-cycle write
        for (int i = 0; i < 7; i++) drive(1'b1, 32'h6000 + 32'(i), 1'b0, 1'b0);
        apply_reset(1'b1, 32'hDEAD_BEEF);
        check("t6_count", 32'(cnt_s), 32'd0);
        check("t6_valid", 32'(vld_d), 32'd0);
        check("t6_drop", dc_d, 32'd0);
        check("t6_uf", 32'(uf_s), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
